gray_pointer_tracker: RTL

//  Read-side pointer controller for a Gray-coded async FIFO. Samples the remote

---
 rtl/gray_pointer_tracker.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/gray_pointer_tracker.sv
// Read-side pointer tracker for a Gray-coded async FIFO.
// Samples the synchronized remote write pointer, vets each Gray step, owns the
// local read pointer (binary and Gray) and reports fill/empty. A RUN/FAULT/RESYNC
// FSM freezes everything on a corrupted sample and realigns under software control.
module gray_pointer_tracker #(
  parameter int WORD_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  areset_n,
  input  logic [WORD_WIDTH-1:0] remote_gray_in,
  input  logic                  read_incr,
  output logic                  read_accept,
  output logic [WORD_WIDTH-1:0] local_gray,
  output logic [WORD_WIDTH-1:0] local_binary,
  output logic [WORD_WIDTH-1:0] fill,
  output logic                  empty,
  output logic                  fault,
  input  logic                  fault_clear
);

  localparam int                    DEPTH_INT = 1 << (WORD_WIDTH - 1);
  localparam logic [WORD_WIDTH-1:0] DEPTH     = DEPTH_INT[WORD_WIDTH-1:0];
  localparam logic [WORD_WIDTH-1:0] ONE       = {{(WORD_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FAULT  = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] gray_q, gray_d;
  logic [WORD_WIDTH-1:0] gray_prev_q, gray_prev_d;
  logic [WORD_WIDTH-1:0] remote_bin_q, remote_bin_d;
  logic                  step_err_q, step_err_d;
  logic [WORD_WIDTH-1:0] fill_q, fill_d;
  logic [WORD_WIDTH-1:0] local_bin_q, local_bin_d;
  logic [WORD_WIDTH-1:0] local_gray_q, local_gray_d;

  logic [WORD_WIDTH-1:0] local_bin_inc;
  logic [WORD_WIDTH-1:0] remote_gap;
  logic                  fault_detect;
  logic                  accept;

  function automatic logic [WORD_WIDTH-1:0] gray_to_bin(input logic [WORD_WIDTH-1:0] g);
    logic [WORD_WIDTH-1:0] b;
    b[WORD_WIDTH-1] = g[WORD_WIDTH-1];
    for (int i = WORD_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WORD_WIDTH-1:0] bin_to_gray(input logic [WORD_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // More than one set bit is exactly when clearing the lowest set bit leaves something behind.
  function automatic logic multi_bit(input logic [WORD_WIDTH-1:0] x);
    return (x & (x - ONE)) != '0;
  endfunction

  // Status outputs and the accept handshake; reads are only honoured in RUN with data present.
  always_comb begin
    empty         = (fill_q == '0) || (state_q != ST_RUN);
    fault         = (state_q == ST_FAULT);
    accept        = read_incr && !empty;
    read_accept   = accept;
    local_bin_inc = local_bin_q + ONE;
    remote_gap    = remote_bin_q - local_bin_q;
    fault_detect  = step_err_q || (remote_gap > DEPTH);
    local_gray    = local_gray_q;
    local_binary  = local_bin_q;
    fill          = fill_q;
  end

  // Next-state and datapath: RUN advances the sampling pipeline unless a fault is seen,
  // FAULT holds everything, RESYNC snaps the local pointer onto the remote one.
  always_comb begin
    state_d      = state_q;
    gray_d       = gray_q;
    gray_prev_d  = gray_prev_q;
    remote_bin_d = remote_bin_q;
    step_err_d   = step_err_q;
    fill_d       = fill_q;
    local_bin_d  = local_bin_q;
    local_gray_d = local_gray_q;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          local_bin_d  = local_bin_inc;
          local_gray_d = bin_to_gray(local_bin_inc);
        end
        if (fault_detect) begin
          state_d = ST_FAULT;
        end else begin
          gray_d       = remote_gray_in;
          gray_prev_d  = gray_q;
          remote_bin_d = gray_to_bin(gray_q);
          step_err_d   = multi_bit(gray_q ^ gray_prev_q);
          // Subtract the post-accept local pointer so fill never counts a word already taken.
          fill_d       = remote_bin_q - (accept ? local_bin_inc : local_bin_q);
        end
      end

      ST_FAULT: begin
        if (fault_clear) begin
          state_d = ST_RESYNC;
        end
      end

      ST_RESYNC: begin
        gray_prev_d  = gray_q;
        step_err_d   = 1'b0;
        local_bin_d  = remote_bin_q;
        local_gray_d = bin_to_gray(remote_bin_q);
        fill_d       = '0;
        state_d      = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state_q      <= ST_RUN;
      gray_q       <= '0;
      gray_prev_q  <= '0;
      remote_bin_q <= '0;
      step_err_q   <= 1'b0;
      fill_q       <= '0;
      local_bin_q  <= '0;
      local_gray_q <= '0;
    end else begin
      state_q      <= state_d;
      gray_q       <= gray_d;
      gray_prev_q  <= gray_prev_d;
      remote_bin_q <= remote_bin_d;
      step_err_q   <= step_err_d;
      fill_q       <= fill_d;
      local_bin_q  <= local_bin_d;
      local_gray_q <= local_gray_d;
    end
  end

endmodule
